// File: rtl/dram_pkg.sv
// Shared types for the fixed-latency DRAM model and controller.
package dram_pkg;
  localparam int DRAM_W = 64;

  typedef struct packed {
    logic [DRAM_W-1:0] addr;
    logic [DRAM_W-1:0] value;
    logic              we;
  } dram_req_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPOND
  } dram_state_t;
endpackage

// File: rtl/dram_ctrl_if.sv
// Cache-side request/response bundle of the DRAM controller.
interface dram_ctrl_if
  import dram_pkg::*;
#(
  parameter int W = DRAM_W
);
  logic         hc_valid_in;
  logic         hc_ready_out;
  logic [W-1:0] hc_addr_in;
  logic [W-1:0] hc_value_in;
  logic         hc_we_in;
  logic         hc_valid_out;
  logic         hc_ready_in;
  logic [W-1:0] hc_addr_out;
  logic [W-1:0] hc_value_out;

  modport master (
    output hc_valid_in, hc_addr_in, hc_value_in,
    output hc_we_in, hc_ready_in,
    input  hc_ready_out, hc_valid_out,
    input  hc_addr_out, hc_value_out
  );

  modport slave (
    input  hc_valid_in, hc_addr_in, hc_value_in,
    input  hc_we_in, hc_ready_in,
    output hc_ready_out, hc_valid_out,
    output hc_addr_out, hc_value_out
  );
endinterface

// File: rtl/dram_ctrl_sync_fifo.sv
// Generic synchronous FIFO; pointers and occupancy clear on reset.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

// File: rtl/dram_ctrl.sv
// In-order fixed-latency main memory below the LLC; reads answer, writes post.
module dram_ctrl
  import dram_pkg::*;
#(
  parameter int W         = DRAM_W,
  parameter int MEM_WORDS = 1024,
  parameter int LAT       = 4,
  parameter int QD        = 4
) (
  input logic        clk_in,
  input logic        rst_in,
  dram_ctrl_if.slave hc
);
  localparam int OB = $clog2(W/8);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int QW = $clog2(QD) + 1;

  dram_state_t   state;
  dram_req_t     head;
  dram_req_t     cur;
  logic [CW-1:0] cnt;
  logic [W-1:0]  mem [MEM_WORDS];
  logic          full;
  logic          empty;
  logic          pop;
  logic          done;
  logic [QW-1:0] count;
  logic [AW-1:0] cur_idx;

  // Ready comes only from the registered count: no pop bypass.
  assign hc.hc_ready_out = count != QW'(QD);
  assign pop     = state == IDLE && !empty;
  assign done    = state == BUSY && cnt == '0;
  assign cur_idx = cur.addr[OB +: AW];

  sync_fifo #(
    .WIDTH($bits(dram_req_t)),
    .DEPTH(QD)
  ) u_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (hc.hc_valid_in && !full),
    .pop   (pop),
    .din   ({hc.hc_addr_in, hc.hc_value_in, hc.hc_we_in}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= IDLE;
      cnt             <= '0;
      cur             <= '0;
      hc.hc_valid_out <= 1'b0;
      hc.hc_addr_out  <= '0;
      hc.hc_value_out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            cur   <= head;
            cnt   <= CW'(LAT-1);
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (cur.we) begin
            state <= IDLE;
          end else begin
            hc.hc_value_out <= mem[cur_idx];
            hc.hc_addr_out  <= cur.addr;
            hc.hc_valid_out <= 1'b1;
            state           <= RESPOND;
          end
        end
        RESPOND: begin
          if (hc.hc_ready_in) begin
            hc.hc_valid_out <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Backing store survives reset; a reset write never reaches BUSY completion.
  always_ff @(posedge clk_in) begin
    if (done && cur.we) mem[cur_idx] <= cur.value;
  end
endmodule

// File: tb/tb_dram_ctrl.sv
// Directed plus randomized checks of dram_ctrl against a word-array model.
module tb_dram_ctrl;
  localparam int LAT = 4;
  localparam int QD  = 4;
  localparam int MW  = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic [63:0] mdl [int];

  dram_ctrl_if #(.W(64)) hc ();

  dram_ctrl #(
    .W(64), .MEM_WORDS(MW), .LAT(LAT), .QD(QD)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .hc     (hc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int widx(input logic [63:0] a);
    return int'((a / 8) % MW);
  endfunction

  function automatic logic [63:0] mget(input logic [63:0] a);
    return mdl.exists(widx(a)) ? mdl[widx(a)] : 64'h0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] v,
                      input logic we, output int acc);
    int n;
    n = 0;
    hc.hc_valid_in = 1'b1;
    hc.hc_addr_in  = a;
    hc.hc_value_in = v;
    hc.hc_we_in    = we;
    while (!hc.hc_ready_out && n < 50) begin
      tick();
      n++;
    end
    if (!hc.hc_ready_out) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: got ready=0 want ready=1 addr %h", a);
      acc = -1;
    end else begin
      tick();
      acc = cyc;
      if (we) mdl[widx(a)] = v;
    end
    hc.hc_valid_in = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [63:0] a,
                      input logic [63:0] v, output int rise);
    int n;
    n = 0;
    hc.hc_ready_in = 1'b1;
    while (!hc.hc_valid_out && n < 100) begin
      tick();
      n++;
    end
    rise = cyc;
    chk({tag, "_valid"}, hc.hc_valid_out, 1);
    chk({tag, "_addr"}, hc.hc_addr_out, a);
    chk({tag, "_data"}, hc.hc_value_out, v);
    tick();
    chk({tag, "_drop"}, hc.hc_valid_out, 0);
  endtask

  initial begin
    int ta, tb, r, n, h, acc_n, issued;
    logic [63:0] old_v, a, v;
    logic [63:0] expa[$];
    logic [63:0] expv[$];
    logic rp;

    hc.hc_valid_in = 1'b0;
    hc.hc_addr_in  = '0;
    hc.hc_value_in = '0;
    hc.hc_we_in    = 1'b0;
    hc.hc_ready_in = 1'b0;

    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tick();
    chk("rst_valid", hc.hc_valid_out, 0);
    chk("rst_addr", hc.hc_addr_out, 0);
    chk("rst_data", hc.hc_value_out, 0);
    chk("rst_ready", hc.hc_ready_out, 1);

    // write then read of the same word, back to back
    send(64'h40, 64'hDEADBEEF_CAFEF00D, 1'b1, ta);
    send(64'h40, 64'h0, 1'b0, tb);
    chk("wr_rd_accept", tb, ta + 1);
    recv("wr_rd", 64'h40, 64'hDEADBEEF_CAFEF00D, r);
    chk("wr_rd_lat", r, (ta + LAT + 1) + LAT + 1);

    send(64'h40, 64'h0, 1'b0, ta);
    recv("rd_iso", 64'h40, mget(64'h40), r);
    chk("rd_iso_lat", r, ta + LAT + 1);

    // address wrap and byte offset
    send(64'h0, 64'd7, 1'b1, ta);
    send(64'h2000, 64'h0, 1'b0, ta);
    recv("wrap_hi", 64'h2000, 64'd7, r);
    send(64'h5, 64'h0, 1'b0, ta);
    recv("wrap_off", 64'h5, 64'd7, r);

    // queue full with the response side stalled
    for (int i = 1; i < 6; i++)
      send(64'(i) * 8, 64'(i) * 64'h1111, 1'b1, ta);
    hc.hc_ready_in = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 6; i++) begin
      hc.hc_valid_in = 1'b1;
      hc.hc_we_in    = 1'b0;
      hc.hc_addr_in  = 64'(i) * 8;
      n = 0;
      while (!hc.hc_ready_out && n < 20) begin
        tick();
        n++;
      end
      if (!hc.hc_ready_out) break;
      tick();
      acc_n++;
    end
    hc.hc_valid_in = 1'b0;
    chk("qfull_accepted", acc_n, 5);
    chk("qfull_ready", hc.hc_ready_out, 0);
    for (int i = 0; i < 5; i++)
      recv("qfull_rsp", 64'(i) * 8, mget(64'(i) * 8), r);
    send(64'd40, 64'h0, 1'b0, ta);
    recv("qfull_6th", 64'd40, mget(64'd40), r);

    // response stall, then next pop one edge after handshake
    hc.hc_ready_in = 1'b0;
    send(64'h40, 64'h0, 1'b0, ta);
    send(64'h8, 64'h0, 1'b0, tb);
    n = 0;
    while (!hc.hc_valid_out && n < 50) begin
      tick();
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", hc.hc_valid_out, 1);
      chk("stall_addr", hc.hc_addr_out, 64'h40);
      chk("stall_data", hc.hc_value_out, mget(64'h40));
      tick();
    end
    hc.hc_ready_in = 1'b1;
    tick();
    h = cyc;
    chk("stall_drop", hc.hc_valid_out, 0);
    recv("stall_next", 64'h8, mget(64'h8), r);
    chk("stall_next_lat", r, h + LAT + 1);

    // reset while a write is in BUSY, with a read queued behind it
    old_v = 64'h1234_5678_9ABC_DEF0;
    send(64'h80, old_v, 1'b1, ta);
    send(64'h80, 64'h0, 1'b0, ta);
    recv("pre_rst", 64'h80, old_v, r);
    hc.hc_ready_in = 1'b0;
    send(64'h80, 64'hFFFF_0000_FFFF_0000, 1'b1, ta);
    send(64'h88, 64'h0, 1'b0, tb);
    tick();
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", hc.hc_valid_out, 0);
    chk("arst_addr", hc.hc_addr_out, 0);
    chk("arst_data", hc.hc_value_out, 0);
    chk("arst_ready", hc.hc_ready_out, 1);
    @(posedge clk);
    #3 rst = 1'b0;
    mdl[widx(64'h80)] = old_v;
    hc.hc_ready_in = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("rst_no_stale", hc.hc_valid_out, 0);
    end
    send(64'h80, 64'h0, 1'b0, ta);
    recv("rst_old", 64'h80, mget(64'h80), r);
    send(64'h40, 64'h0, 1'b0, ta);
    recv("rst_keep", 64'h40, 64'hDEADBEEF_CAFEF00D, r);

    // randomized traffic with random response back-pressure
    issued = 0;
    rp = 1'b0;
    n = 0;
    hc.hc_ready_in = 1'b0;
    while ((issued < 60 || expa.size() > 0) && n < 5000) begin
      if (hc.hc_valid_in && rp) begin
        if (hc.hc_we_in) begin
          mdl[widx(hc.hc_addr_in)] = hc.hc_value_in;
        end else begin
          expa.push_back(hc.hc_addr_in);
          expv.push_back(mget(hc.hc_addr_in));
        end
        issued++;
        hc.hc_valid_in = 1'b0;
      end
      if (expa.size() == 0) begin
        chk("rnd_unexpected", hc.hc_valid_out, 0);
      end else if (hc.hc_valid_out) begin
        chk("rnd_addr", hc.hc_addr_out, expa[0]);
        chk("rnd_data", hc.hc_value_out, expv[0]);
      end
      hc.hc_ready_in = ($urandom_range(0, 3) != 0);
      if (hc.hc_valid_out && hc.hc_ready_in && expa.size() > 0) begin
        void'(expa.pop_front());
        void'(expv.pop_front());
      end
      if (!hc.hc_valid_in && issued < 60 && $urandom_range(0, 2) != 0) begin
        a = (64'($urandom_range(0, 15)) << 3)
          | 64'($urandom_range(0, 7))
          | (64'($urandom_range(0, 3)) << 13)
          | (64'($urandom_range(0, 1)) << 63);
        v = {32'($urandom), 32'($urandom)};
        hc.hc_valid_in = 1'b1;
        hc.hc_addr_in  = a;
        hc.hc_value_in = v;
        hc.hc_we_in    = $urandom_range(0, 1) == 1;
      end
      rp = hc.hc_ready_out;
      tick();
      n++;
    end
    hc.hc_valid_in = 1'b0;
    chk("rnd_issued", issued, 60);
    chk("rnd_drained", expa.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
